// File: rtl/vc_out_arbiter.sv
// vc_out_arbiter: output-port arbiter for the virtual channel router.
// Shares one output link among NREQ requesters, one flit per cycle, with
// per-VC wormhole ownership (head to tail) and per-VC downstream credits.
// Grant is combinational from current state; all state updates land on
// the next rising clk edge.
module vc_out_arbiter #(
    parameter int NREQ    = 4,
    parameter int NVC     = 2,
    parameter int VCW     = 1,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*VCW-1:0] req_vc,
    input  logic [NREQ-1:0]     head,
    input  logic [NREQ-1:0]     tail,
    input  logic [NVC-1:0]      credit_in,
    output logic [NREQ-1:0]     gnt,
    output logic                out_valid,
    output logic [VCW-1:0]      out_vc,
    output logic [NVC-1:0]      vc_busy,
    output logic                cred_err
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Per-VC state and round-robin pointer
    logic [CW-1:0]   cred   [NVC];
    logic [IDW-1:0]  own_id [NVC];
    logic [NVC-1:0]  own_vld;
    logic [IDW-1:0]  rr_ptr;

    // Arbitration results
    logic [NREQ-1:0] elig;
    logic            found;
    logic            grant;
    logic [IDW-1:0]  gidx;
    logic [VCW-1:0]  gvc;
    logic            ghead;
    logic            gtail;
    logic [NVC-1:0]  vc_hit;

    // Eligibility: target VC exists, has credits, and is either owned by this
    // requester or free while this requester presents a head flit.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned u = 0; u < NVC; u++) begin
                if (req[i] && (req_vc[i*VCW +: VCW] == VCW'(u)) && (cred[u] != '0)) begin
                    if (own_vld[u]) begin
                        if (own_id[u] == IDW'(i)) elig[i] = 1'b1;
                    end else if (head[i]) begin
                        elig[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Round-robin pick: first eligible requester scanning upward from rr_ptr.
    always_comb begin
        int idx;
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + int'(k)) % NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = IDW'(idx);
            end
        end
    end

    // Decode the winning flit and drive the link outputs (muted during reset).
    always_comb begin
        grant  = found & clr_n;
        gvc    = req_vc[gidx*VCW +: VCW];
        ghead  = head[gidx];
        gtail  = tail[gidx];
        gnt    = grant ? (NREQ'(1) << gidx) : '0;
        out_vc = grant ? gvc : '0;
        vc_hit = '0;
        for (int unsigned u = 0; u < NVC; u++) begin
            if (grant && (gvc == VCW'(u))) vc_hit[u] = 1'b1;
        end
    end

    assign out_valid = |gnt;
    assign vc_busy   = own_vld;

    // State update: pointer advance, VC ownership, credit accounting, overflow flag.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rr_ptr   <= '0;
            own_vld  <= '0;
            cred_err <= 1'b0;
            for (int unsigned u = 0; u < NVC; u++) begin
                own_id[u] <= '0;
                cred[u]   <= CW'(CREDITS);
            end
        end else begin
            if (grant) begin
                rr_ptr <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
            end
            for (int unsigned u = 0; u < NVC; u++) begin
                // Tail wins over head so a single-flit packet never locks the VC.
                if (vc_hit[u]) begin
                    if (gtail) begin
                        own_vld[u] <= 1'b0;
                    end else if (ghead) begin
                        own_vld[u] <= 1'b1;
                        own_id[u]  <= gidx;
                    end
                end
                case ({vc_hit[u], credit_in[u]})
                    2'b10: cred[u] <= cred[u] - 1'b1;
                    2'b01: begin
                        if (cred[u] == CW'(CREDITS)) cred_err <= 1'b1;
                        else                         cred[u]  <= cred[u] + 1'b1;
                    end
                    default: cred[u] <= cred[u];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vc_out_arbiter.sv
// tb_vc_out_arbiter: directed scoreboard bench for vc_out_arbiter (defaults).
// Expected outputs are queued as each cycle's stimulus is driven and popped
// when the outputs are sampled on the falling edge of the same cycle.
module tb_vc_out_arbiter;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [3:0] req, req_vc, head, tail;
    logic [1:0] credit_in;
    logic [3:0] gnt;
    logic       out_valid;
    logic [0:0] out_vc;
    logic [1:0] vc_busy;
    logic       cred_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic       vc;
        logic [1:0] busy;
        logic       err;
        logic       state;
    } exp_t;

    exp_t sb[$];

    vc_out_arbiter #(.NREQ(4), .NVC(2), .VCW(1), .CREDITS(4), .CW(3)) dut (
        .clk(clk), .clr_n(clr_n), .req(req), .req_vc(req_vc), .head(head),
        .tail(tail), .credit_in(credit_in), .gnt(gnt), .out_valid(out_valid),
        .out_vc(out_vc), .vc_busy(vc_busy), .cred_err(cred_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the rising edge, queue the expectation,
    // then compare at the falling edge.
    task automatic step(input string tag, input logic rn, input logic [3:0] r,
                        input logic [3:0] rv, input logic [3:0] h, input logic [3:0] t,
                        input logic [1:0] ci, input logic [3:0] eg, input logic evc,
                        input logic [1:0] eb, input logic ee, input logic st);
        exp_t e;
        @(posedge clk);
        #1;
        clr_n = rn; req = r; req_vc = rv; head = h; tail = t; credit_in = ci;
        sb.push_back('{tag, eg, evc, eb, ee, st});
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
        check({e.tag, ".valid"}, 32'(out_valid), 32'(|e.gnt));
        check({e.tag, ".vc"}, 32'(out_vc), 32'(e.vc));
        if (e.state) begin
            check({e.tag, ".busy"}, 32'(vc_busy), 32'(e.busy));
            check({e.tag, ".err"}, 32'(cred_err), 32'(e.err));
        end
    endtask

    // Reset with requests present (grants must stay muted), then confirm cleared state.
    task automatic do_reset(input string tag);
        step({tag, ".rst0"}, 1'b0, 4'hF, 4'h0, 4'hF, 4'hF, 2'b00, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        step({tag, ".rst1"}, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    initial begin
        clr_n = 1'b0; req = '0; req_vc = '0; head = '0; tail = '0; credit_in = '0;
        repeat (2) @(posedge clk);

        // Single-flit packet, zero-cycle grant; credit return afterwards must not overflow.
        do_reset("s1");
        step("s1.c1", 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'b00, 4'b0001, 0, 2'b00, 0, 1);
        step("s1.c2", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 2'b00, 0, 1);
        step("s1.c3", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b01, 4'b0000, 0, 2'b00, 0, 1);
        step("s1.c4", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 2'b00, 0, 1);

        // Two 3-flit packets contending for VC0: wormhole lock then handover.
        do_reset("s2");
        step("s2.c1", 1, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 2'b01, 4'b0001, 0, 2'b00, 0, 1);
        step("s2.c2", 1, 4'b0011, 4'b0000, 4'b0010, 4'b0000, 2'b01, 4'b0001, 0, 2'b01, 0, 1);
        step("s2.c3", 1, 4'b0011, 4'b0000, 4'b0010, 4'b0001, 2'b01, 4'b0001, 0, 2'b01, 0, 1);
        step("s2.c4", 1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 2'b01, 4'b0010, 0, 2'b00, 0, 1);
        step("s2.c5", 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'b01, 4'b0010, 0, 2'b01, 0, 1);
        step("s2.c6", 1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'b01, 4'b0010, 0, 2'b01, 0, 1);
        step("s2.c7", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 2'b00, 0, 1);

        // Round-robin over four single-flit requesters, VCs alternating.
        do_reset("s3");
        for (int n = 0; n < 8; n++) begin
            logic [3:0] eg;
            logic       ev;
            eg = 4'b0001 << (n % 4);
            ev = 1'((n % 4) & 1);
            step("s3.rr", 1, 4'b1111, 4'b1010, 4'b1111, 4'b1111,
                 ev ? 2'b10 : 2'b01, eg, ev, 2'b00, 0, 1);
        end

        // 5-flit packet on VC1 with credits running out; credit return enables next cycle.
        do_reset("s4");
        step("s4.f1", 1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 2'b00, 4'b0100, 1, 2'b00, 0, 1);
        step("s4.f2", 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 2'b00, 4'b0100, 1, 2'b10, 0, 1);
        step("s4.f3", 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 2'b00, 4'b0100, 1, 2'b10, 0, 1);
        step("s4.f4", 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 2'b00, 4'b0100, 1, 2'b10, 0, 1);
        step("s4.stall", 1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'b00, 4'b0000, 0, 2'b10, 0, 1);
        step("s4.crd", 1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'b10, 4'b0000, 0, 2'b10, 0, 1);
        step("s4.f5", 1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'b00, 4'b0100, 1, 2'b10, 0, 1);
        step("s4.idle", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 2'b00, 0, 1);

        // Grant plus credit leaves cred[0] full, so the next credit overflows (sticky).
        do_reset("s5");
        step("s5.both", 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'b01, 4'b0001, 0, 2'b00, 0, 1);
        step("s5.ovf", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b01, 4'b0000, 0, 2'b00, 0, 1);
        step("s5.err1", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 2'b00, 1, 1);
        step("s5.err2", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 2'b00, 1, 1);

        // Reset mid-packet: ownership dropped, credits refilled, body flit refused.
        do_reset("s6");
        step("s6.head", 1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 2'b00, 4'b0100, 0, 2'b00, 0, 1);
        step("s6.body", 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0100, 0, 2'b01, 0, 1);
        step("s6.rst", 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 2'b01, 0, 1);
        step("s6.nob1", 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'b11, 4'b0000, 0, 2'b00, 0, 1);
        step("s6.nob2", 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 2'b00, 1, 1);
        step("s6.rehead", 1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 2'b00, 4'b0100, 0, 2'b00, 1, 1);
        step("s6.body2", 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0100, 0, 2'b01, 1, 1);
        step("s6.tail", 1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'b00, 4'b0100, 0, 2'b01, 1, 1);
        step("s6.idle", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 2'b00, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
